// File: rtl/amc7823_spi_responder.sv
// AMC7823 SPI responder: oversampled SPI slave in front of a 64x16 register file with a local port.
// Optional multi-word transfers with address auto-increment: define AMC7823_AUTOINC_EN.
module amc7823_spi_responder #(
  parameter int CLK_PER_SCLK_MIN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ss_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic        loc_we,
  input  logic [5:0]  loc_addr,
  input  logic [15:0] loc_wdata,
  output logic [15:0] loc_rdata,
  output logic        spi_wr_stb,
  output logic [5:0]  spi_wr_addr,
  output logic [15:0] spi_wr_data,
  output logic [7:0]  abort_cnt
);

  if (CLK_PER_SCLK_MIN < 8) begin : g_clk_ratio_check
    $error("CLK_PER_SCLK_MIN must be at least 8");
  end

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t      state;
  logic [1:0]  ss_sync, sclk_sync, mosi_sync;
  logic        sclk_d, armed, is_read;
  logic [3:0]  cnt;
  logic [15:0] shift_in, shift_out;
  logic [5:0]  addr;
  logic [15:0] mem [64];
`ifdef AMC7823_AUTOINC_EN
  logic [4:0]  end_addr;
  logic [5:0]  next_addr;
  assign next_addr = {addr[5], addr[4:0] + 5'd1};
`endif

  logic        ss_hi, mosi_b, rise, fall;
  logic [15:0] word_in;
  logic [5:0]  cmd_addr;

  assign ss_hi    = ss_sync[1];
  assign mosi_b   = mosi_sync[1];
  assign rise     = sclk_sync[1] & ~sclk_d;
  assign fall     = ~sclk_sync[1] & sclk_d;
  assign word_in  = {shift_in[14:0], mosi_b};
  // The 6-bit file address keeps only the low page bit above the 5-bit register address.
  assign cmd_addr = {word_in[11], word_in[10:6]};

  // Two-flop synchronizers and SCLK edge history; ss_sync resets low so a frame needs ss_n high first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= 2'b00;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[0], ss_n};
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
    end
  end

  // Register file: an SPI write beats a same-address local write in the same cycle.
  always_ff @(posedge clk) begin
    if (loc_we && !(spi_wr_stb && (spi_wr_addr == loc_addr))) begin
      mem[loc_addr] <= loc_wdata;
    end
    if (spi_wr_stb) begin
      mem[spi_wr_addr] <= spi_wr_data;
    end
  end

  // Registered local read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loc_rdata <= 16'h0000;
    end else begin
      loc_rdata <= mem[loc_addr];
    end
  end

  // Frame state machine with registered MISO, write strobe and abort counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      armed       <= 1'b0;
      is_read     <= 1'b0;
      cnt         <= 4'd0;
      shift_in    <= 16'h0000;
      shift_out   <= 16'h0000;
      addr        <= 6'd0;
`ifdef AMC7823_AUTOINC_EN
      end_addr    <= 5'd0;
`endif
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      spi_wr_stb  <= 1'b0;
      spi_wr_addr <= 6'd0;
      spi_wr_data <= 16'h0000;
      abort_cnt   <= 8'd0;
    end else begin
      spi_wr_stb <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= 4'd0;
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          if (ss_hi) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            state <= CMD;
          end
        end
        CMD: begin
          if (ss_hi) begin
            state <= IDLE;
            if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
          end else if (rise) begin
            shift_in <= word_in;
            if (cnt == 4'd15) begin
              cnt       <= 4'd0;
              is_read   <= word_in[15];
              addr      <= cmd_addr;
              shift_out <= mem[cmd_addr];
`ifdef AMC7823_AUTOINC_EN
              end_addr  <= word_in[4:0];
`endif
              state     <= DATA;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (ss_hi) begin
            state   <= IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
          end else if (rise) begin
            shift_in <= word_in;
            if (cnt == 4'd15) begin
              cnt <= 4'd0;
              if (!is_read) begin
                spi_wr_stb  <= 1'b1;
                spi_wr_addr <= addr;
                spi_wr_data <= word_in;
              end
`ifdef AMC7823_AUTOINC_EN
              // Comparing with < also ends the frame after one word when end < start.
              if (addr[4:0] < end_addr) begin
                addr      <= next_addr;
                shift_out <= mem[next_addr];
              end else begin
                state   <= DONE;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
              end
`else
              state   <= DONE;
              miso    <= 1'b0;
              miso_oe <= 1'b0;
`endif
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else if (fall) begin
            miso      <= is_read & shift_out[15];
            miso_oe   <= is_read;
            shift_out <= {shift_out[14:0], 1'b0};
          end
        end
        DONE: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          if (ss_hi) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amc7823_spi_responder.sv
// Scoreboard bench for amc7823_spi_responder: directed SPI frames, queued expected write strobes and read words.
module tb_amc7823_spi_responder;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ss_n = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic        miso, miso_oe, loc_we = 1'b0;
  logic [5:0]  loc_addr = 6'd0;
  logic [15:0] loc_wdata = 16'h0000, loc_rdata;
  logic        spi_wr_stb;
  logic [5:0]  spi_wr_addr;
  logic [15:0] spi_wr_data;
  logic [7:0]  abort_cnt;

  int checks = 0, errors = 0;
  logic [21:0] wr_q [$];
  logic [15:0] rd_q [$];
  logic [15:0] rbits = 16'h0000;
  int          nb = 0;

  amc7823_spi_responder #(.CLK_PER_SCLK_MIN(8)) dut (
    .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .loc_we(loc_we), .loc_addr(loc_addr),
    .loc_wdata(loc_wdata), .loc_rdata(loc_rdata), .spi_wr_stb(spi_wr_stb),
    .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data), .abort_cnt(abort_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write-strobe monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && spi_wr_stb) begin
      if (wr_q.size() == 0) begin
        check("unexpected_wr_stb", {10'd0, spi_wr_addr, spi_wr_data}, 32'hFFFF_FFFF);
      end else begin
        check("spi_wr", {10'd0, spi_wr_addr, spi_wr_data}, {10'd0, wr_q.pop_front()});
      end
    end
  end

  // Read monitor: master samples MISO on SCLK rise; 16 enabled bits make one word, disabled MISO must be 0.
  always @(posedge sclk) begin
    if (miso_oe) begin
      rbits = {rbits[14:0], miso};
      nb++;
      if (nb == 16) begin
        nb = 0;
        if (rd_q.size() == 0) check("unexpected_rd_word", {16'd0, rbits}, 32'hFFFF_FFFF);
        else check("spi_rd", {16'd0, rbits}, {16'd0, rd_q.pop_front()});
      end
    end else begin
      check("miso_idle", {31'd0, miso}, 32'd0);
    end
  end

  // Full frame: 16 command bits followed by repeated data bits, nclk SCLK cycles in total.
  task automatic spi_xfer(input logic [15:0] cmd, input logic [15:0] wdata, input int nclk);
    ss_n = 1'b0;
    #60;
    for (int i = 0; i < nclk; i++) begin
      mosi = (i < 16) ? cmd[15 - i] : wdata[15 - ((i - 16) % 16)];
      #50 sclk = 1'b1;
      #50 sclk = 1'b0;
    end
    #50 ss_n = 1'b1;
    mosi = 1'b0;
    #100;
  endtask

  task automatic loc_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    loc_we = 1'b1; loc_addr = a; loc_wdata = d;
    @(negedge clk);
    loc_we = 1'b0;
  endtask

  task automatic loc_read(input string name, input logic [5:0] a, input logic [15:0] exp);
    @(negedge clk);
    loc_addr = a;
    @(negedge clk);
    check(name, {16'd0, loc_rdata}, {16'd0, exp});
  endtask

  // Waits for the strobe cycle and issues a local write in that same cycle.
  task automatic collide(input logic [5:0] a, input logic [15:0] d);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = spi_wr_stb;
    end
    if (!seen) check("collision_timeout", 32'd0, 32'd1);
    else begin
      loc_we = 1'b1; loc_addr = a; loc_wdata = d;
      @(negedge clk);
      loc_we = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    #23;
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_wr", {9'd0, spi_wr_stb, spi_wr_addr, spi_wr_data}, 32'd0);
    check("rst_loc_rdata", {16'd0, loc_rdata}, 32'd0);
    check("rst_abort_cnt", {24'd0, abort_cnt}, 32'd0);
    #20 rst_n = 1'b1;
    #100;

    // Read of a locally written register.
    loc_write(6'h05, 16'hBEEF);
    rd_q.push_back(16'hBEEF);
    spi_xfer(16'h8140, 16'h0000, 32);
    check("rd_bits_left", nb, 32'd0);

    // Write page 1 address 9 and read it back locally.
    wr_q.push_back({6'h29, 16'h1234});
    spi_xfer(16'h0A40, 16'h1234, 32);
    loc_read("loc_rd_0x29", 6'h29, 16'h1234);

    // Abort after 10 data bits, then saturate the abort counter.
    loc_write(6'h07, 16'h1111);
    spi_xfer(16'h01C0, 16'hFFFF, 26);
    check("abort_cnt_1", {24'd0, abort_cnt}, 32'd1);
    loc_read("abort_unchanged", 6'h07, 16'h1111);
    for (int k = 0; k < 299; k++) spi_xfer(16'h0000, 16'h0000, 0);
    check("abort_cnt_sat", {24'd0, abort_cnt}, 32'd255);

    // Same-address collision: SPI value wins.
    wr_q.push_back({6'h03, 16'hAAAA});
    fork
      spi_xfer(16'h00C0, 16'hAAAA, 32);
      collide(6'h03, 16'h5555);
    join
    loc_read("collide_same", 6'h03, 16'hAAAA);

    // Different addresses in the strobe cycle: both writes land.
    wr_q.push_back({6'h03, 16'hBBBB});
    fork
      spi_xfer(16'h00C0, 16'hBBBB, 32);
      collide(6'h04, 16'h4444);
    join
    loc_read("collide_diff_spi", 6'h03, 16'hBBBB);
    loc_read("collide_diff_loc", 6'h04, 16'h4444);

    // Multi-word read request over addresses 1..2.
    loc_write(6'h01, 16'h0A01);
    loc_write(6'h02, 16'h0B02);
    rd_q.push_back(16'h0A01);
`ifdef AMC7823_AUTOINC_EN
    rd_q.push_back(16'h0B02);
`endif
    spi_xfer(16'h8042, 16'h0000, 64);
    check("autoinc_bits_left", nb, 32'd0);
    check("autoinc_rd_q_empty", rd_q.size(), 32'd0);

    // Asynchronous reset in the middle of a read data phase.
    fork
      spi_xfer(16'h8140, 16'h0000, 32);
      begin
        #2235;
        check("pre_rst_oe", {31'd0, miso_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", {31'd0, miso}, 32'd0);
        check("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
        #50 rst_n = 1'b1;
        nb = 0;
      end
    join
    check("post_rst_abort_cnt", {24'd0, abort_cnt}, 32'd0);
    rd_q.push_back(16'hBEEF);
    spi_xfer(16'h8140, 16'h0000, 32);

    #200;
    check("wr_q_empty", wr_q.size(), 32'd0);
    check("rd_q_empty", rd_q.size(), 32'd0);
    check("final_bits_left", nb, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
